// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Optional feature macro used by the top level: REGFILE_BYPASS_EN.
package regfile_pkg;

  // Sweep-clear controller states. The values are one-hot, so the two
  // other 2-bit codes are illegal and the FSM sends them back to idle.
  typedef enum logic [1:0] {
    RF_IDLE  = 2'b01,
    RF_CLEAR = 2'b10
  } rf_state_t;

  // Entry 0 is hardwired to zero: it cannot be written and always reads 0.
  localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sweep-clear controller. A start pulse in idle launches a sweep that
// zeroes entries 1..NREGS-1, one per cycle. busy is high for the whole
// sweep. The current state is exported for observation.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              start,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output rf_state_t         state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  logic [ADDR_W-1:0] counter;

  // State register and sweep counter. The counter stops at the last entry
  // instead of wrapping, and start is ignored while a sweep is running.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state   <= RF_IDLE;
      counter <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (start) begin
            state   <= RF_CLEAR;
            counter <= FIRST_ADDR;
          end
        end
        RF_CLEAR: begin
          if (counter == LAST_ADDR) begin
            state <= RF_IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= RF_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_en   = (state == RF_CLEAR);
  assign clr_addr = counter;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with a hardwired-zero entry 0
// and a sequential sweep-clear engine.
// Optional feature macro: REGFILE_BYPASS_EN -- a read port whose address
// matches a valid write in the same cycle returns the write data instead
// of the stored value.
//
// Write handshake: there is no ready signal. A write is committed on the
// rising edge where ctrl_writeEnable=1, busy=0, ctrl_clear=0 and the
// address is non-zero and in range; write_ack is high for exactly the one
// following cycle for each committed write, and low otherwise.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NREAD  = 2
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_W-1:0]       ctrl_writeReg,
  input  logic [DATA_W-1:0]       data_writeReg,
  input  logic                    ctrl_clear,
  input  logic [NREAD*ADDR_W-1:0] ctrl_readReg,
  output logic [NREAD*DATA_W-1:0] data_readReg,
  output logic                    busy,
  output logic                    write_ack
);

  // When the address space is exactly filled, every address is in range.
  localparam bit FULL_RANGE = (NREGS == (1 << ADDR_W));
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

  logic              fsmBusy;
  logic              clrEn;
  logic [ADDR_W-1:0] clrAddr;
  rf_state_t         clearState;
  logic              readBlank;
  logic              writeInRange;
  logic              writeValid;
  logic [DATA_W-1:0] entry [NREGS];

  regfile_clear_fsm #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) uClearFsm (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .start        (ctrl_clear),
    .busy         (fsmBusy),
    .clr_en       (clrEn),
    .clr_addr     (clrAddr),
    .state        (clearState)
  );

  assign busy      = fsmBusy;
  assign readBlank = (clearState == RF_CLEAR);

  if (FULL_RANGE) begin : gWrFull
    assign writeInRange = 1'b1;
  end else begin : gWrPart
    assign writeInRange = (ctrl_writeReg < ADDR_W'(NREGS));
  end

  // A clear request in the same cycle wins over a write.
  assign writeValid = ctrl_writeEnable && !fsmBusy && !ctrl_clear &&
                      (ctrl_writeReg != ZERO_ADDR) && writeInRange;

  // Acknowledge each committed write for one cycle after its edge.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      write_ack <= 1'b0;
    end else begin
      write_ack <= writeValid;
    end
  end

  // Storage: entry 0 is a constant, the rest are reset/clear/write registers.
  for (genvar i = 0; i < NREGS; i++) begin : gEntry
    if (i == RF_ZERO_ADDR) begin : gZero
      assign entry[i] = '0;
    end else begin : gReg
      logic [DATA_W-1:0] q;
      // Sweep zeroing and writes never coincide: writes are blocked while busy.
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
          q <= '0;
        end else if (clrEn && (clrAddr == ADDR_W'(i))) begin
          q <= '0;
        end else if (writeValid && (ctrl_writeReg == ADDR_W'(i))) begin
          q <= data_writeReg;
        end
      end
      assign entry[i] = q;
    end
  end

  // One combinational read mux per port.
  for (genvar k = 0; k < NREAD; k++) begin : gRead
    logic [ADDR_W-1:0] rAddr;
    logic              rInRange;
    logic [DATA_W-1:0] rData;

    assign rAddr = ctrl_readReg[k*ADDR_W +: ADDR_W];

    if (FULL_RANGE) begin : gRdFull
      assign rInRange = 1'b1;
    end else begin : gRdPart
      assign rInRange = (rAddr < ADDR_W'(NREGS));
    end

    // Zero for entry 0, out-of-range addresses and during a sweep.
    always_comb begin
      rData = '0;
      if (!readBlank && rInRange && (rAddr != ZERO_ADDR)) begin
`ifdef REGFILE_BYPASS_EN
        if (writeValid && (rAddr == ctrl_writeReg)) begin
          rData = data_writeReg;
        end else begin
          rData = entry[rAddr];
        end
`else
        rData = entry[rAddr];
`endif
      end
    end

    assign data_readReg[k*DATA_W +: DATA_W] = rData;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (32x32/2 ports and 16-bit x8/3 ports)
// driven from shared stimulus and checked each cycle against a reference model.
module tb_regfile_param;

  localparam int DW_A = 32, NREGS_A = 32, AW_A = 5, NR_A = 2;
  localparam int DW_B = 16, NREGS_B = 8,  AW_B = 3, NR_B = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rstN  = 1'b0;
  always #5 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic        clr = 1'b0;
  logic [4:0]  ra [3];

  logic [NR_A*AW_A-1:0] raA;
  logic [NR_B*AW_B-1:0] raB;
  logic [NR_A*DW_A-1:0] rdA;
  logic [NR_B*DW_B-1:0] rdB;
  logic busyA, busyB, ackA, ackB;

  assign raA = {ra[1], ra[0]};
  assign raB = {ra[2][2:0], ra[1][2:0], ra[0][2:0]};

  regfile_param #(.DATA_W(DW_A), .NREGS(NREGS_A), .NREAD(NR_A)) dutA (
    .clock            (clock),
    .ctrl_reset_n     (rstN),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wa),
    .data_writeReg    (wd),
    .ctrl_clear       (clr),
    .ctrl_readReg     (raA),
    .data_readReg     (rdA),
    .busy             (busyA),
    .write_ack        (ackA)
  );

  regfile_param #(.DATA_W(DW_B), .NREGS(NREGS_B), .NREAD(NR_B)) dutB (
    .clock            (clock),
    .ctrl_reset_n     (rstN),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wa[2:0]),
    .data_writeReg    (wd[15:0]),
    .ctrl_clear       (clr),
    .ctrl_readReg     (raB),
    .data_readReg     (rdB),
    .busy             (busyB),
    .write_ack        (ackB)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem [2][32];
  bit          mBusy [2];
  int          left [2];
  bit          mAck [2];
  int          nregs [2] = '{NREGS_A, NREGS_B};
  int          nread [2] = '{NR_A, NR_B};
  logic [31:0] exp_q [$];

  int compared   = 0;
  int mismatched = 0;
  int busyCntA   = 0;
  int busyCntB   = 0;

  function automatic logic [31:0] dmask(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic int addrOf(int d, logic [4:0] a);
    return (d == 0) ? int'(a) : int'(a[2:0]);
  endfunction

  function automatic bit wrValid(int d);
    int a;
    a = addrOf(d, wa);
    return we && !mBusy[d] && !clr && (a != 0) && (a < nregs[d]);
  endfunction

  function automatic logic [31:0] expRead(int d, int k);
    int a;
    a = addrOf(d, ra[k]);
    if (mBusy[d] || (a == 0) || (a >= nregs[d])) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wrValid(d) && (a == addrOf(d, wa))) return wd & dmask(d);
`endif
    return mem[d][a];
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
      mBusy[d] = 1'b0;
      left[d]  = 0;
      mAck[d]  = 1'b0;
    end
  endtask

  // Apply one rising edge to the model using the currently held inputs.
  task automatic modelEdge();
    bit wv;
    int a;
    if (!rstN) begin
      modelReset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      wv = wrValid(d);
      a  = addrOf(d, wa);
      if (!mBusy[d] && clr) begin
        mBusy[d] = 1'b1;
        left[d]  = nregs[d] - 1;
        for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
      end else if (mBusy[d]) begin
        left[d]--;
        if (left[d] == 0) mBusy[d] = 1'b0;
      end
      if (wv) mem[d][a] = wd & dmask(d);
      mAck[d] = wv;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] expv);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic checkAll(string tag);
    logic [31:0] got;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < nread[d]; k++) exp_q.push_back(expRead(d, k));
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nread[d]; k++) begin
        got = (d == 0) ? rdA[k*32 +: 32] : {16'h0, rdB[k*16 +: 16]};
        checkVal($sformatf("%s d%0d port%0d", tag, d, k), got, exp_q.pop_front());
      end
    end
    checkVal({tag, " busyA"}, {31'b0, busyA}, {31'b0, mBusy[0]});
    checkVal({tag, " busyB"}, {31'b0, busyB}, {31'b0, mBusy[1]});
    checkVal({tag, " ackA"},  {31'b0, ackA},  {31'b0, mAck[0]});
    checkVal({tag, " ackB"},  {31'b0, ackB},  {31'b0, mAck[1]});
    if (busyA) busyCntA++;
    if (busyB) busyCntB++;
  endtask

  // ---------------- driver ----------------
  // Inputs are set by the caller shortly after a rising edge.
  task automatic cycle(string tag);
    @(negedge clock);
    checkAll(tag);
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic setReads(int a);
    for (int k = 0; k < 3; k++) ra[k] = 5'(a);
  endtask

  task automatic randReads();
    for (int k = 0; k < 3; k++) ra[k] = 5'($urandom_range(0, 31));
  endtask

  task automatic readAll(string tag);
    we = 1'b0; clr = 1'b0;
    for (int a = 0; a < 32; a++) begin
      setReads(a);
      ra[1] = 5'(31 - a);
      cycle(tag);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    setReads(0);
    modelReset();
    #1;
    checkAll("inReset");
    repeat (2) @(posedge clock);
    #1 rstN = 1'b1;

    // 1: everything reads zero after reset
    readAll("afterReset");

    // 2: write r5 then read back on all ports; ack for one cycle
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; setReads(5);
    cycle("wr5");
    we = 1'b0;
    cycle("rd5");
    cycle("rd5ackGone");

    // 3: writes to r0 are dropped
    we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; setReads(0);
    cycle("wr0");
    we = 1'b0;
    cycle("rd0");

    // 4: same-cycle read of the address being written
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; setReads(7); ra[1] = 5'd5;
    cycle("bypass7");
    we = 1'b0;
    cycle("after7");

    // 5: fill, sweep-clear, blocked write and ignored re-trigger
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = $urandom(); randReads();
      cycle("fill");
    end
    we = 1'b1; wa = 5'd9; wd = $urandom(); clr = 1'b1; randReads();
    cycle("clrStart");
    clr = 1'b0;
    busyCntA = 0; busyCntB = 0;
    for (int i = 0; i < 40; i++) begin
      we = (i == 3); wa = 5'd3; wd = $urandom();
      clr = (i == 5);
      randReads();
      cycle("sweep");
    end
    checkVal("busyLenA", 32'(busyCntA), 32'(NREGS_A - 1));
    checkVal("busyLenB", 32'(busyCntB), 32'(NREGS_B - 1));
    readAll("afterSweep");

    // 6: reset in the middle of a sweep
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = $urandom(); randReads();
      cycle("refill");
    end
    we = 1'b0; clr = 1'b1;
    cycle("clrStart2");
    clr = 1'b0;
    repeat (9) begin
      randReads();
      cycle("sweep2");
    end
    @(negedge clock);
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("asyncRst");
    cycle("heldRst");
    rstN = 1'b1;
    readAll("afterRst");
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE_F00D; setReads(9);
    cycle("wr9");
    we = 1'b0;
    cycle("rd9");

    // 7: random traffic
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom();
      clr = ($urandom_range(0, 59) == 0);
      randReads();
      if ($urandom_range(0, 3) == 0) ra[0] = wa;
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
